// File: rtl/alu_profiler.sv
// alu_profiler: times ALU operations in clock cycles and queues one
// {op_code, sat, count} record per completed operation in a FIFO.
//
// Ports:
//   wb_clk_i   sole clock, rising edge
//   resetb     async active-low reset, release synchronised
//   alu_rst    1 = ALU held in reset (profiler idles)
//   op_code    current ALU operation
//   op_done    one-cycle pulse, operation complete
//   clear      synchronous flush of FIFO and overflow flag
//   rd_en      pop head record (ignored when empty)
//   rec_valid  FIFO non-empty
//   rec_data   head record {op_code, sat, count}, zero when empty
//   level      number of stored records
//   overflow   sticky, a record was dropped on a full FIFO
//   busy       profiler is in RUN

module alu_profiler #(
   parameter int CNT_W = 32,
   parameter int DEPTH = 8
) (
   input  logic                     wb_clk_i,
   input  logic                     resetb,
   input  logic                     alu_rst,
   input  logic [3:0]               op_code,
   input  logic                     op_done,
   input  logic                     clear,
   input  logic                     rd_en,
   output logic                     rec_valid,
   output logic [CNT_W+4:0]         rec_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [3:0]       op;
      logic             sat;
      logic [CNT_W-1:0] cnt;
   } rec_t;

   // ---------------------------------------------------------------
   // Reset: assertion is immediate, release is retimed by one flop so
   // the first state update lands on the second edge after release.
   // ---------------------------------------------------------------
   logic rst_n;

   always_ff @(posedge wb_clk_i or negedge resetb) begin
      if (!resetb) begin
         rst_n <= 1'b0;
      end else begin
         rst_n <= 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   state_t state_q;
   state_t state_d;
   logic   run;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (!alu_rst) state_d = RUN;
         RUN:  if (alu_rst)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      run  = (state_q == RUN);
      busy = run;
   end

   // ---------------------------------------------------------------
   // Interval counter
   // ---------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] rec_cnt;
   logic             rec_sat;
   logic             push_req;

   // alu_rst wins over a coincident op_done: no record is produced.
   assign push_req = run & op_done & ~alu_rst;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!run || alu_rst || op_done) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // The op_done cycle itself is counted. The counter never decreases
   // inside an interval, so it touched the ceiling iff the final count
   // sits on it.
   always_comb begin
      rec_cnt = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
      rec_sat = (rec_cnt == CNT_MAX);
   end

   // ---------------------------------------------------------------
   // Record FIFO
   // ---------------------------------------------------------------
   rec_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   level_q;
   logic            ovf_q;
   logic            full;
   logic            do_pop;
   logic            do_push;
   logic            drop;
   rec_t            new_rec;

   always_comb begin
      full      = (level_q == LVL_FULL);
      rec_valid = (level_q != '0);
      do_pop    = rd_en & rec_valid;
      // A pop in the same cycle frees the slot, so a full FIFO still
      // accepts the push.
      do_push   = push_req & ~clear & (~full | do_pop);
      drop      = push_req & ~clear & full & ~do_pop;
      new_rec   = '{op: op_code, sat: rec_sat, cnt: rec_cnt};
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else if (clear) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop) begin
            level_q <= level_q + LW'(1);
         end else if (do_pop && !do_push) begin
            level_q <= level_q - LW'(1);
         end
         if (drop) ovf_q <= 1'b1;
      end
   end

   // Storage carries no reset; rec_data is masked by rec_valid.
   always_ff @(posedge wb_clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= new_rec;
      end
   end

   always_comb begin
      rec_data = rec_valid ? mem[rd_ptr] : '0;
      level    = level_q;
      overflow = ovf_q;
   end

endmodule

// File: tb/tb_alu_profiler.sv
// tb_alu_profiler: directed checks of alu_profiler
// (CNT_W=8, DEPTH=8) against hand-computed records.

module tb_alu_profiler;

   localparam int CW = 8;
   localparam int DP = 8;

   logic          wb_clk_i = 1'b0;
   logic          resetb;
   logic          alu_rst;
   logic [3:0]    op_code;
   logic          op_done;
   logic          clear;
   logic          rd_en;
   logic          rec_valid;
   logic [CW+4:0] rec_data;
   logic [3:0]    level;
   logic          overflow;
   logic          busy;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   alu_profiler #(
      .CNT_W(CW),
      .DEPTH(DP)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .resetb    (resetb),
      .alu_rst   (alu_rst),
      .op_code   (op_code),
      .op_done   (op_done),
      .clear     (clear),
      .rd_en     (rd_en),
      .rec_valid (rec_valid),
      .rec_data  (rec_data),
      .level     (level),
      .overflow  (overflow),
      .busy      (busy)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rec(input logic [3:0] c,
                                       input logic       s,
                                       input logic [7:0] n);
      return {19'd0, c, s, n};
   endfunction

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   // op_done lands on the gap-th cycle of the interval
   task automatic run_op(input logic [3:0] c, input int gap);
      op_done = 1'b0;
      repeat (gap - 1) step();
      op_code = c;
      op_done = 1'b1;
      step();
      op_done = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      resetb  = 1'b0;
      alu_rst = 1'b1;
      op_code = 4'h0;
      op_done = 1'b0;
      clear   = 1'b0;
      rd_en   = 1'b0;
      repeat (3) step();

      chk("rst_valid", 32'(rec_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_data", 32'(rec_data), 32'd0);

      // release with alu_rst low: RUN only after second edge
      resetb  = 1'b1;
      alu_rst = 1'b0;
      step();
      chk("sync_edge1_busy", 32'(busy), 32'd0);
      step();
      chk("sync_edge2_busy", 32'(busy), 32'd1);

      // single op, 10 cycles
      run_op(4'h3, 10);
      chk("op10_data", 32'(rec_data), rec(4'h3, 1'b0, 8'd10));
      chk("op10_level", 32'(level), 32'd1);
      chk("op10_busy", 32'(busy), 32'd1);

      alu_rst = 1'b1;
      step();
      chk("idle_keeps_rec", 32'(level), 32'd1);
      pop();
      chk("pop1_level", 32'(level), 32'd0);
      chk("pop1_valid", 32'(rec_valid), 32'd0);
      chk("pop1_data", 32'(rec_data), 32'd0);

      // three spaced ops, FIFO order
      alu_rst = 1'b0;
      step();
      run_op(4'h1, 5);
      run_op(4'h2, 1);
      run_op(4'h4, 7);
      chk("three_level", 32'(level), 32'd3);
      alu_rst = 1'b1;
      step();
      chk("three_head0", 32'(rec_data), rec(4'h1, 1'b0, 8'd5));
      pop();
      chk("three_lvl2", 32'(level), 32'd2);
      chk("three_head1", 32'(rec_data), rec(4'h2, 1'b0, 8'd1));
      pop();
      chk("three_lvl1", 32'(level), 32'd1);
      chk("three_head2", 32'(rec_data), rec(4'h4, 1'b0, 8'd7));
      pop();
      chk("three_lvl0", 32'(level), 32'd0);

      // nine ops without pop: overflow
      alu_rst = 1'b0;
      step();
      for (int i = 0; i < 9; i++) begin
         run_op(4'(i), i + 1);
         if (i == 7) begin
            chk("fill8_level", 32'(level), 32'd8);
            chk("fill8_ovf", 32'(overflow), 32'd0);
         end
      end
      chk("ovf_level", 32'(level), 32'd8);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_head", 32'(rec_data), rec(4'h0, 1'b0, 8'd1));

      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_level", 32'(level), 32'd0);
      chk("clr_ovf", 32'(overflow), 32'd0);
      chk("clr_valid", 32'(rec_valid), 32'd0);
      chk("clr_busy", 32'(busy), 32'd1);

      // full FIFO, push and pop together
      alu_rst = 1'b1;
      step();
      alu_rst = 1'b0;
      step();
      for (int k = 0; k < 8; k++) run_op(4'(8 + k), 2);
      chk("full2_level", 32'(level), 32'd8);
      step();
      op_code = 4'hF;
      op_done = 1'b1;
      rd_en   = 1'b1;
      step();
      op_done = 1'b0;
      rd_en   = 1'b0;
      chk("pp_level", 32'(level), 32'd8);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_head", 32'(rec_data), rec(4'h9, 1'b0, 8'd2));
      alu_rst = 1'b1;
      step();
      for (int k = 1; k < 8; k++) begin
         chk($sformatf("drain_%0d", k), 32'(rec_data),
             rec(4'(8 + k), 1'b0, 8'd2));
         pop();
      end
      chk("drain_tail", 32'(rec_data), rec(4'hF, 1'b0, 8'd2));
      pop();
      chk("drain_empty", 32'(level), 32'd0);
      pop();
      chk("empty_pop_lvl", 32'(level), 32'd0);
      chk("empty_pop_vld", 32'(rec_valid), 32'd0);

      // saturation
      alu_rst = 1'b0;
      step();
      run_op(4'h5, 300);
      run_op(4'h6, 4);
      chk("sat_level", 32'(level), 32'd2);
      chk("sat_head", 32'(rec_data), rec(4'h5, 1'b1, 8'd255));
      pop();
      chk("after_sat", 32'(rec_data), rec(4'h6, 1'b0, 8'd4));

      // alu_rst on op_done cycle
      step();
      op_code = 4'hA;
      op_done = 1'b1;
      alu_rst = 1'b1;
      step();
      op_done = 1'b0;
      chk("abort_level", 32'(level), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);

      // async reset with five records
      alu_rst = 1'b0;
      step();
      repeat (4) run_op(4'h7, 1);
      chk("pre_rst_level", 32'(level), 32'd5);
      resetb = 1'b0;
      #1;
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_data", 32'(rec_data), 32'd0);
      chk("arst_valid", 32'(rec_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      step();
      resetb = 1'b1;
      step();
      chk("rel_edge1_busy", 32'(busy), 32'd0);
      step();
      chk("rel_edge2_busy", 32'(busy), 32'd1);
      chk("rel_level", 32'(level), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
